// File: rtl/dpram_arbiter.sv
// dpram_arbiter: zero-fills the shared 64x8 dual-port RAM after reset, then
// round-robin arbitrates two requesters independently onto its write and read ports.
module dpram_arbiter #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 8,
    parameter bit          INIT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_wr_addr,
    input  logic [2*DATA_W-1:0]   req_wr_data,
    output logic [1:0]            wr_gnt,
    input  logic [1:0]            req_re,
    input  logic [2*ADDR_W-1:0]   req_rd_addr,
    output logic [1:0]            rd_gnt,
    output logic [1:0]            rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  init_done,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_wr_addr,
    output logic [DATA_W-1:0]     ram_data_in,
    output logic                  ram_re,
    output logic [ADDR_W-1:0]     ram_rd_addr,
    input  logic [DATA_W-1:0]     ram_data_out
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic                wr_last_q, rd_last_q;
    logic [1:0]          rd_own_q1, rd_own_q2;

    logic                we_d, re_d;
    logic [ADDR_W-1:0]   wa_d, ra_d;
    logic [DATA_W-1:0]   wd_d;

    // last = index of the requester granted most recently; on a tie the other one wins
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] g;
        unique case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = last ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wr_gnt     = '0;
        rd_gnt     = '0;
        we_d       = 1'b0;
        wa_d       = '0;
        wd_d       = '0;
        re_d       = 1'b0;
        ra_d       = '0;
        unique case (state_q)
            ST_INIT: begin
                we_d       = 1'b1;
                wa_d       = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                wr_gnt = rr_pick(req_we, wr_last_q);
                rd_gnt = rr_pick(req_re, rd_last_q);
                if (|wr_gnt) begin
                    we_d = 1'b1;
                    wa_d = wr_gnt[1] ? req_wr_addr[ADDR_W +: ADDR_W] : req_wr_addr[0 +: ADDR_W];
                    wd_d = wr_gnt[1] ? req_wr_data[DATA_W +: DATA_W] : req_wr_data[0 +: DATA_W];
                end
                if (|rd_gnt) begin
                    re_d = 1'b1;
                    ra_d = rd_gnt[1] ? req_rd_addr[ADDR_W +: ADDR_W] : req_rd_addr[0 +: ADDR_W];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RST_STATE;
            init_cnt_q  <= '0;
            wr_last_q   <= 1'b1;
            rd_last_q   <= 1'b1;
            rd_own_q1   <= '0;
            rd_own_q2   <= '0;
            ram_we      <= 1'b0;
            ram_wr_addr <= '0;
            ram_data_in <= '0;
            ram_re      <= 1'b0;
            ram_rd_addr <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            if (|wr_gnt)
                wr_last_q <= wr_gnt[1];
            if (|rd_gnt)
                rd_last_q <= rd_gnt[1];
            // owner travels alongside the RAM's address register and its read-data register
            rd_own_q1   <= rd_gnt;
            rd_own_q2   <= rd_own_q1;
            ram_we      <= we_d;
            ram_wr_addr <= wa_d;
            ram_data_in <= wd_d;
            ram_re      <= re_d;
            ram_rd_addr <= ra_d;
        end
    end

    assign rd_valid  = rd_own_q2;
    assign rd_data   = ram_data_out;
    assign init_done = (state_q == ST_RUN);

endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Controller and arbiter sharing one 64x8 dual-port RAM (synchronous write port, synchronous read port, 1-cycle registered read data) between two requesters.
- After reset, optionally sweeps every RAM location to zero, then round-robin arbitrates writes and reads independently onto the RAM's write and read ports.
- Returns read data to the owning requester with a fixed latency.
- Sits between client logic and the RAM instance; it is the only block that drives the RAM.

Parameters:
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_we  in  2  per-requester write request (bit i = requester i).
- req_wr_addr  in  2*ADDR_W  write addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wr_data  in  2*DATA_W  write data, same packing.
- wr_gnt  out  2  one-hot write grant, combinational; grant = accepted this cycle.
- req_re  in  2  per-requester read request.
- req_rd_addr  in  2*ADDR_W  read addresses, same packing.
- rd_gnt  out  2  one-hot read grant, combinational.
- rd_valid  out  2  one-hot read-data-valid, indexed by owner.
- rd_data  out  DATA_W  read data; meaningful only while rd_valid != 0.
- init_done  out  1  high once the controller is in RUN.
- ram_we  out  1  RAM write enable, registered.
- ram_wr_addr  out  ADDR_W  RAM write address, registered.
- ram_data_in  out  DATA_W  RAM write data, registered.
- ram_re  out  1  RAM read enable, registered.
- ram_rd_addr  out  ADDR_W  RAM read address, registered.
- ram_data_out  in  DATA_W  RAM registered read data.

Behaviour:
- Reset (reset low, asynchronous):
  - State = INIT (INIT_EN=1) or RUN (INIT_EN=0); init counter = 0; both round-robin pointers favour requester 0.
  - All registered outputs 0; read pipeline owner flags cleared; init_done=0 (1 if INIT_EN=0).
- FSM states: INIT and RUN only.
- INIT:
  - Each cycle: ram_we=1, ram_wr_addr=counter, ram_data_in=0, ram_re=0; wr_gnt=rd_gnt=0.
  - Counter increments; after address 2**ADDR_W-1 is issued, move to RUN next cycle.
  - INIT takes exactly 2**ADDR_W cycles after reset release. Requests during INIT are ignored, not queued.
- RUN:
  - The write arbiter and read arbiter are independent, and each is round-robin over two requesters.
  - If only one requester asserts, it is granted. If both assert, the one not granted most recently on that port wins. The pointer updates only on a grant.
  - Write grant to requester i at cycle t: ram_we=1, ram_wr_addr and ram_data_in carry requester i's values at t+1. No write grant means ram_we=0 at t+1.
  - Read grant to requester i at cycle t: ram_re=1, ram_rd_addr at t+1; RAM data available at t+2.
  - rd_valid[i]=1 and rd_data=ram_data_out at t+2, driven from a 2-stage owner pipeline. Reads fully pipelined: one grant per cycle; back-to-back grants give back-to-back valids.
  - Read and write to the same address granted in the same cycle: read returns the old contents; no forwarding.
  - Write after read to the same address in a later cycle is ordered by grant cycle.
- Reset mid-operation:
  - In-flight reads are dropped; no rd_valid is produced for them.
  - INIT restarts from address 0.
- Requesters hold request, address and data stable until granted. The arbiter does not sample ungranted values.

Test Plan:
- INIT_EN=1, release reset: ram_we=1 for 64 consecutive cycles with ram_wr_addr 0..63 and ram_data_in=0; init_done rises the cycle after address 63; no grants during the sweep, even with req_we=2'b11.
- Requester 0 writes 0xA5 to addr 5; later reads addr 5: wr_gnt=01; ram_we/addr 5/0xA5 one cycle later; rd_gnt=01, then rd_valid=01 with rd_data=0xA5 exactly two cycles after rd_gnt.
- Both requesters write continuously (req0 → addr 1 data 0x11, req1 → addr 2 data 0x22) for 4 cycles: wr_gnt sequence 01,10,01,10; RAM write stream matches.
- Same cycle: write 0x3C to addr 9 and read addr 9, previous value 0x00: rd_data=0x00; a read one cycle later returns 0x3C.
- Back-to-back reads alternating requesters at addrs 3,4,3: rd_valid sequence 01,10,01 on consecutive cycles with correct data.
- Assert reset at sweep address 20 and during an in-flight read: outputs go to 0 immediately; the sweep restarts at 0; the dropped read produces no rd_valid.
